// File: rtl/asip_fetch_pkg.sv
// Shared types and constants for the ASIP instruction fetch front-end.
package asip_fetch_pkg;

    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 24;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    typedef logic [DATA_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    localparam addr_t RESET_PC_DEFAULT = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; head is read from registered storage.
module fetch_fifo
    import asip_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic               head_valid_o,
    output logic [ENTRY_W-1:0] head_data_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push, do_pop;

    // Push at full is legal only because the same-cycle pop frees the slot.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// In-order instruction prefetch with credit-limited requests and redirect flush.
// Perf counters are present only when PREFETCH_PERF_EN is defined.
module instr_prefetch_queue
    import asip_fetch_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
`ifdef PREFETCH_PERF_EN
    output logic [15:0]       perf_fetches,
    output logic [15:0]       perf_drops,
    output logic [15:0]       perf_stalls,
`endif
    output logic              dbg_state
);

    // Handshakes: a request or a pop transfers on any cycle where valid && ready;
    // valid never depends on ready, and a pending request is withdrawn only by a redirect.

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_e       state_q, state_d;
    addr_t              fetch_pc_q, fetch_pc_d;
    addr_t              pc_tag_q, pc_tag_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   fifo_count, inflight_after_rsp;
    logic [CNT_W:0]     credit_used;
    logic               req_fire, push, pop, rsp_drop;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t       head_entry, push_entry;

    assign credit_used   = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign mem_req_valid = !reset && (state_q == FETCH) && !redirect_valid && (credit_used < DEPTH_C);
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response arriving with a redirect belongs to the abandoned stream.
    assign inflight_after_rsp = inflight_q - CNT_W'(mem_rsp_valid);
    assign rsp_drop           = mem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    assign push               = mem_rsp_valid && !rsp_drop;
    assign pop                = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_tag_d   = pc_tag_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_after_rsp + CNT_W'(req_fire);
        if (req_fire) fetch_pc_d = fetch_pc_q + addr_t'(1);
        if (push) pc_tag_d = pc_tag_q + addr_t'(1);
        if (mem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        if ((state_q == FLUSH) && (drop_cnt_d == '0)) state_d = FETCH;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            pc_tag_d   = redirect_pc;
            drop_cnt_d = inflight_after_rsp;
            state_d    = (inflight_after_rsp != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            pc_tag_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_tag_q   <= pc_tag_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign push_entry = '{instr: mem_rsp_data, pc: pc_tag_q};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (redirect_valid),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .head_valid_o (out_valid),
        .head_data_o  (head_bits),
        .count_o      (fifo_count)
    );

    assign head_entry = fetch_entry_t'(head_bits);
    assign out_instr  = head_entry.instr;
    assign out_pc     = head_entry.pc;
    assign dbg_state  = state_q;

`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_fetches_q, perf_drops_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetches_q <= '0;
            perf_drops_q   <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (req_fire) perf_fetches_q <= sat_inc16(perf_fetches_q);
            if (rsp_drop) perf_drops_q <= sat_inc16(perf_drops_q);
            if (!out_valid && (state_q == FETCH)) perf_stalls_q <= sat_inc16(perf_stalls_q);
        end
    end

    assign perf_fetches = perf_fetches_q;
    assign perf_drops   = perf_drops_q;
    assign perf_stalls  = perf_stalls_q;
`endif

endmodule
